// File: rtl/cmp_sequencer.sv
// Multi-cycle set-less-than controller: subtracts A-B one SLICE per cycle, LSB first,
// then registers N/V/C/Z and the signed/unsigned less-than result. Optional abort port: CMP_ABORT_EN.
module cmp_sequencer #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
`ifdef CMP_ABORT_EN
    input  logic             abort,
`endif
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             comparison,
    output logic             flag_n,
    output logic             flag_v,
    output logic             flag_c,
    output logic             flag_z,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             sgn, carry, zacc;
    logic [CW-1:0]    cnt;
    logic [SLICE:0]   sum;
    logic             cin_msb, last, accept, kill;
    logic             n_new, v_new, c_new, z_new;

    // Operands shift right each cycle, so the active slice is always the low SLICE bits.
    always_comb begin
        sum     = {1'b0, a_sh[SLICE-1:0]} + {1'b0, ~b_sh[SLICE-1:0]} + {{SLICE{1'b0}}, carry};
        // Carry into the slice MSB recovered from the MSB sum bit and its two addends.
        cin_msb = sum[SLICE-1] ^ a_sh[SLICE-1] ^ ~b_sh[SLICE-1];
        c_new   = sum[SLICE];
        n_new   = sum[SLICE-1];
        v_new   = cin_msb ^ sum[SLICE];
        z_new   = zacc & (sum[SLICE-1:0] == '0);
        last    = (cnt == CW'(NSLICE - 1));
        accept  = start & (state == IDLE);
    end

`ifdef CMP_ABORT_EN
    assign kill = abort & (state != IDLE);
`else
    assign kill = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = SUB;
            SUB:     if (last)      state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
        if (kill) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            sgn        <= 1'b0;
            carry      <= 1'b0;
            zacc       <= 1'b0;
            cnt        <= '0;
            comparison <= 1'b0;
            flag_n     <= 1'b0;
            flag_v     <= 1'b0;
            flag_c     <= 1'b0;
            flag_z     <= 1'b0;
        end else if (kill) begin
            comparison <= 1'b0;
            flag_n     <= 1'b0;
            flag_v     <= 1'b0;
            flag_c     <= 1'b0;
            flag_z     <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            sgn   <= is_signed;
            carry <= 1'b1;
            zacc  <= 1'b1;
            cnt   <= '0;
        end else if (state == SUB) begin
            a_sh  <= a_sh >> SLICE;
            b_sh  <= b_sh >> SLICE;
            carry <= c_new;
            zacc  <= z_new;
            cnt   <= cnt + 1'b1;
            if (last) begin
                flag_c     <= c_new;
                flag_v     <= v_new;
                flag_n     <= n_new;
                flag_z     <= z_new;
                comparison <= sgn ? (n_new ^ v_new) : ~c_new;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign res_valid = (state == DONE);
    assign busy      = (state == SUB) || (state == DONE);

endmodule

// File: tb/tb_cmp_sequencer.sv
// Self-checking bench for cmp_sequencer: directed vector table, corner sequences
// (backpressure, async reset, optional abort) and random ops against an arithmetic model.
module tb_cmp_sequencer;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int NSLICE = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start, is_signed, res_ready;
    logic [WIDTH-1:0] a, b;
    logic             in_ready, res_valid, comparison, flag_n, flag_v, flag_c, flag_z, busy;
`ifdef CMP_ABORT_EN
    logic             abort;
`endif

    int checks = 0;
    int failures = 0;

    cmp_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
`ifdef CMP_ABORT_EN
        .abort(abort),
`endif
        .in_ready(in_ready), .a(a), .b(b), .is_signed(is_signed),
        .res_valid(res_valid), .res_ready(res_ready), .comparison(comparison),
        .flag_n(flag_n), .flag_v(flag_v), .flag_c(flag_c), .flag_z(flag_z), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va, vb;
        logic        sg;
        logic [4:0]  exp;  // {cmp, n, v, c, z}
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: flags of A-B from whole-word arithmetic; less-than from native compares.
    function automatic logic [4:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic sg);
        logic [32:0] d;
        logic n, v, c, z, lt;
        d  = {1'b0, ma} + {1'b0, ~mb} + 33'd1;
        c  = d[32];
        n  = d[31];
        z  = (ma == mb);
        v  = (ma[31] != mb[31]) && (d[31] != ma[31]);
        lt = sg ? ($signed(ma) < $signed(mb)) : (ma < mb);
        return {lt, n, v, c, z};
    endfunction

    function automatic logic [4:0] outs();
        return {comparison, flag_n, flag_v, flag_c, flag_z};
    endfunction

    // Starts at #1 after a posedge with DUT idle; returns with DUT idle again.
    task automatic do_op(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic ts, input logic [4:0] exp, input int hold);
        int lat;
        logic [4:0] snap;
        a = ta; b = tb_; is_signed = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; is_signed = ~ts;
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'(NSLICE));
        chk({name, " flags"}, 64'(outs()), 64'(exp));
        snap = outs();
        for (int i = 0; i < hold; i++) begin
            start = 1'b1;
            @(posedge clk); #1;
            chk({name, " hold valid"}, 64'({res_valid, in_ready, busy}), 64'b101);
            chk({name, " hold outs"}, 64'(outs()), 64'(snap));
        end
        // start during the handshake cycle must not be taken
        start = 1'b1; res_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; res_ready = 1'b0;
        chk({name, " release"}, 64'({res_valid, in_ready, busy}), 64'b010);
        chk({name, " kept outs"}, 64'(outs()), 64'(snap));
    endtask

    vec_t vt[$];

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int          lat;

        vt.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b1, 5'b11010});
        vt.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b0, 5'b01010});
        vt.push_back('{32'h80000000, 32'h00000001, 1'b1, 5'b10110});
        vt.push_back('{32'h80000000, 32'h00000001, 1'b0, 5'b00110});
        vt.push_back('{32'h12345678, 32'h12345678, 1'b1, 5'b00011});
        vt.push_back('{32'h12345678, 32'h12345678, 1'b0, 5'b00011});
        vt.push_back('{32'h00000001, 32'h00000002, 1'b0, 5'b11000});
        vt.push_back('{32'h00000005, 32'h00000003, 1'b1, 5'b00010});
        vt.push_back('{32'h00000000, 32'h00000000, 1'b0, 5'b00011});
        vt.push_back('{32'h7FFFFFFF, 32'h80000000, 1'b1, 5'b01100});
        vt.push_back('{32'h7FFFFFFF, 32'h80000000, 1'b0, 5'b11100});

        reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; res_ready = 1'b0; a = '0; b = '0;
`ifdef CMP_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("reset state", 64'({in_ready, res_valid, busy, outs()}), 64'b100_00000);

        foreach (vt[i]) do_op($sformatf("vec%0d", i), vt[i].va, vt[i].vb, vt[i].sg, vt[i].exp, 0);

        // backpressure with start pulses ignored while DONE
        do_op("bp", 32'hFFFFFFFF, 32'h00000001, 1'b1, 5'b11010, 3);

        // async reset in the 2nd SUB cycle
        a = 32'h80000000; b = 32'h1; is_signed = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        chk("rst mid", 64'({res_valid, busy, outs()}), 64'b0);
        @(negedge clk) reset_n = 1'b1;
        #1 chk("rst release", 64'({in_ready, res_valid, busy}), 64'b100);
        lat = 0;
        repeat (6) begin @(posedge clk); #1 if (res_valid) lat++; end
        chk("rst no valid", 64'(lat), 64'd0);
        do_op("after rst", 32'd5, 32'd3, 1'b1, 5'b00010, 0);

`ifdef CMP_ABORT_EN
        a = 32'hFFFFFFFF; b = 32'h1; is_signed = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort idle", 64'({in_ready, busy, outs()}), 64'b10_00000);
        lat = 0;
        repeat (6) begin @(posedge clk); #1 if (res_valid) lat++; end
        chk("abort no valid", 64'(lat), 64'd0);
        do_op("after abort", 32'h80000000, 32'h1, 1'b1, 5'b10110, 0);
`endif

        for (int k = 0; k < 40; k++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom);
            case (k % 5)
                0: rb = ra;
                1: rb = ra ^ 32'h80000000;
                2: rb = ra + 1;
                default: ;
            endcase
            do_op($sformatf("rnd%0d", k), ra, rb, rs, model(ra, rb, rs), k % 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1);
    end

endmodule

// File: doc/cmp_sequencer.md
Name: cmp_sequencer

Overview:
Multi-cycle compare controller that sequences a WIDTH-bit set-less-than operation over a narrow SLICE-bit subtract slice, LSB slice first.
- Accumulates the carry chain across slices and derives the final N, V, C and Z flags.
- Selects the signed (N^V) or unsigned (~C) less-than result.
- Sits between the MIPS decode/execute stage and the VGA-side requester.
- Uses a start/in_ready request handshake and a res_valid/res_ready result handshake.

Parameters:
- WIDTH, 32: operand width in bits; must be a multiple of SLICE.
- SLICE, 8: bits processed per cycle.
- NSLICE, WIDTH/SLICE (derived, localparam): cycles per compare.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request valid; accepted when start & in_ready at a clk edge.
- in_ready  out  1  high only in IDLE.
- a  in  WIDTH  operand A; sampled on accept.
- b  in  WIDTH  operand B; sampled on accept.
- is_signed  in  1  1 = signed compare (slt), 0 = unsigned compare (sltu); sampled on accept.
- res_valid  out  1  result valid; held until res_ready.
- res_ready  in  1  consumer accepts result.
- comparison  out  1  1 when A < B under the selected signedness.
- flag_n  out  1  MSB of A-B.
- flag_v  out  1  signed overflow of A-B.
- flag_c  out  1  carry out of A+~B+1 (1 = no borrow).
- flag_z  out  1  A-B == 0.
- busy  out  1  high in SUB or DONE.

Behaviour:
- Reset is asynchronous on reset_n low:
  - State goes to IDLE; operand regs, slice counter, carry and all outputs are cleared to 0, except in_ready = 1.
  - This includes reset mid-SUB or mid-DONE: the operation is lost and no res_valid is produced.
- States: IDLE, SUB, DONE.
- IDLE:
  - in_ready = 1, res_valid = 0.
  - On start=1: latch a, b, is_signed; set carry = 1, cnt = 0, zacc = 1; go to SUB.
- SUB, one slice per cycle:
  - sum = a[cnt] + ~b[cnt] + carry, computed over SLICE bits.
  - carry <= slice carry-out.
  - zacc <= zacc & (sum == 0).
  - cnt increments by 1.
- On the slice with cnt == NSLICE-1, register the flags:
  - flag_c = carry-out.
  - flag_v = carry into bit SLICE-1 XOR carry-out.
  - flag_n = sum[SLICE-1].
  - flag_z = zacc & (sum == 0).
  - comparison = is_signed ? (flag_n ^ flag_v) : ~flag_c.
  - Go to DONE.
- cnt is clog2(NSLICE) bits wide; it never wraps inside SUB because the exit at NSLICE-1 is unconditional.
- Latency: res_valid rises exactly NSLICE cycles after the accept edge, i.e. 4 cycles at the default parameters.
- DONE:
  - res_valid = 1; comparison and all flags stay stable until the handshake.
  - On res_ready=1: go to IDLE next edge; res_valid drops; flag/comparison outputs keep their last values.
- in_ready is 0 in SUB and DONE, and start is ignored there.
  - A start asserted in the same cycle as the DONE handshake is not accepted; it is accepted the following cycle in IDLE.
  - Minimum issue interval is therefore NSLICE+2 cycles.
- Operand changes on a or b after accept have no effect.
- With SLICE == WIDTH, NSLICE = 1: accept, SUB for 1 cycle, then DONE.

Optional Feature:
Macro: CMP_ABORT_EN
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in SUB or DONE forces IDLE at the next edge; res_valid = 0 and comparison/flags are cleared to 0.
  - abort in IDLE has no effect; abort takes priority over the res_ready handshake.
  - start in the same cycle as abort is not accepted.
- Not defined:
  - No abort port; SUB always runs to completion.

Test Plan:
1. Signed negative: a=0xFFFFFFFF, b=0x00000001, is_signed=1 -> res_valid 4 cycles after accept; comparison=1, flag_n=1, flag_v=0, flag_c=1, flag_z=0. Repeat with is_signed=0 -> comparison=0.
2. Signed overflow: a=0x80000000, b=0x00000001, is_signed=1 -> flag_n=0, flag_v=1, comparison=1. Same operands with is_signed=0 -> comparison=0 (flag_c=1).
3. Equality and unsigned borrow:
   - a=b=0x12345678 -> flag_z=1, comparison=0 for both signedness settings.
   - a=0x00000001, b=0x00000002, is_signed=0 -> flag_c=0, comparison=1.
4. Backpressure: hold res_ready=0 for 3 cycles after res_valid -> res_valid and outputs stable, in_ready=0, start pulses ignored; res_ready=1 -> IDLE next edge and in_ready=1.
5. Reset mid-operation: drive reset_n=0 asynchronously in the 2nd SUB cycle -> immediately res_valid=0, in_ready=1 (once reset_n is high), outputs 0; a subsequent compare of 5 vs 3 (signed) gives comparison=0.
6. (CMP_ABORT_EN) Pulse abort in the 3rd SUB cycle -> IDLE next edge, no res_valid ever asserted for that request; the next request completes normally with 4-cycle latency.
